// File: rtl/wb_arbiter_pkg.sv
// Shared widths and the source-select encoding for the write-back arbiter.
package wb_arbiter_pkg;

    localparam int CPU_DW        = 32;
    localparam int REG_AW        = 5;
    localparam int REG_COUNT     = 1 << REG_AW;
    localparam int WB_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_EX,
        SRC_FIFO,
        SRC_LT
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Completion buffer: synchronous FIFO of {rd, data} entries with full/empty flags.
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PW = $clog2(DEPTH);

    // Extra MSB distinguishes full from empty when the index bits match.
    logic [PW:0]  wr_ptr_q, rd_ptr_q;
    logic [W-1:0] mem_q [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q[PW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

// File: rtl/wb_arbiter.sv
// Write-back stage: arbitrates ex results, buffered and direct long-latency
// completions onto the single register-file write port, and tracks pending destinations.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DW         = CPU_DW,
    parameter int AW         = REG_AW,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_wr_en_i,
    input  logic [AW-1:0] ex_wr_addr_i,
    input  logic [DW-1:0] ex_wr_data_i,
    input  logic          iss_valid_i,
    input  logic [AW-1:0] iss_rd_i,
    output logic          iss_ready_o,
    input  logic          lt_valid_i,
    input  logic [AW-1:0] lt_rd_i,
    input  logic [DW-1:0] lt_data_i,
    output logic          lt_ready_o,
    input  logic [AW-1:0] rs1_addr_i,
    input  logic [AW-1:0] rs2_addr_i,
    output logic          rs1_busy_o,
    output logic          rs2_busy_o,
    output logic          reg_wr_en_o,
    output logic [AW-1:0] reg_wr_addr_o,
    output logic [DW-1:0] reg_wr_data_o
);

    localparam int NREG = 1 << AW;
    localparam int EW   = AW + DW;

    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [EW-1:0] fifo_head;
    logic [AW-1:0] head_rd;
    logic [DW-1:0] head_data;

    logic          ex_fire, lt_acc, iss_acc;
    wb_src_e       src;

    logic [NREG-1:0] pending_q, pending_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;

    assign head_rd   = fifo_head[EW-1:DW];
    assign head_data = fifo_head[DW-1:0];

    // Writes to x0 are filtered here so they never arbitrate, queue or mark pending.
    assign ex_fire     = ex_wr_en_i && (ex_wr_addr_i != '0);
    assign lt_ready_o  = !fifo_full;
    assign lt_acc      = lt_valid_i && lt_ready_o && (lt_rd_i != '0);
    assign iss_ready_o = !pending_q[iss_rd_i];
    assign iss_acc     = iss_valid_i && iss_ready_o && (iss_rd_i != '0);

    assign rs1_busy_o = pending_q[rs1_addr_i] && (rs1_addr_i != '0);
    assign rs2_busy_o = pending_q[rs2_addr_i] && (rs2_addr_i != '0);

    always_comb begin
        src = SRC_NONE;
        if (ex_fire)          src = SRC_EX;
        else if (!fifo_empty) src = SRC_FIFO;
        else if (lt_acc)      src = SRC_LT;
    end

    assign fifo_push = lt_acc && (src != SRC_LT);
    assign fifo_pop  = (src == SRC_FIFO);

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        wr_en_d   = 1'b1;
        wr_addr_d = '0;
        wr_data_d = '0;
        pending_d = pending_q;
        case (src)
            SRC_EX: begin
                wr_addr_d = ex_wr_addr_i;
                wr_data_d = ex_wr_data_i;
            end
            SRC_FIFO: begin
                wr_addr_d          = head_rd;
                wr_data_d          = head_data;
                pending_d[head_rd] = 1'b0;
            end
            SRC_LT: begin
                wr_addr_d          = lt_rd_i;
                wr_data_d          = lt_data_i;
                pending_d[lt_rd_i] = 1'b0;
            end
            default: wr_en_d = 1'b0;
        endcase
        // Applied after the clear so a same-edge reissue keeps the register pending.
        if (iss_acc) pending_d[iss_rd_i] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
        end
    end

    assign reg_wr_en_o   = wr_en_q;
    assign reg_wr_addr_o = wr_addr_q;
    assign reg_wr_data_o = wr_data_q;

    wb_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i ({lt_rd_i, lt_data_i}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Decode stalls on busy; an ex write racing an in-flight op would be lost on completion.
    ex_to_pending_rd : assert property (@(posedge clk) disable iff (rst)
        !(ex_fire && pending_q[ex_wr_addr_i]));

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by randomized
// traffic, all compared against a queue-based model of the write-back rules.
module tb_wb_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int NREG  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ex_wr_en_i, iss_valid_i, lt_valid_i;
    logic [AW-1:0] ex_wr_addr_i, iss_rd_i, lt_rd_i, rs1_addr_i, rs2_addr_i;
    logic [DW-1:0] ex_wr_data_i, lt_data_i;
    logic          iss_ready_o, lt_ready_o, rs1_busy_o, rs2_busy_o, reg_wr_en_o;
    logic [AW-1:0] reg_wr_addr_o;
    logic [DW-1:0] reg_wr_data_o;

    wb_arbiter #(.DW(DW), .AW(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_wr_en_i    (ex_wr_en_i),
        .ex_wr_addr_i  (ex_wr_addr_i),
        .ex_wr_data_i  (ex_wr_data_i),
        .iss_valid_i   (iss_valid_i),
        .iss_rd_i      (iss_rd_i),
        .iss_ready_o   (iss_ready_o),
        .lt_valid_i    (lt_valid_i),
        .lt_rd_i       (lt_rd_i),
        .lt_data_i     (lt_data_i),
        .lt_ready_o    (lt_ready_o),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .rs1_busy_o    (rs1_busy_o),
        .rs2_busy_o    (rs2_busy_o),
        .reg_wr_en_o   (reg_wr_en_o),
        .reg_wr_addr_o (reg_wr_addr_o),
        .reg_wr_data_o (reg_wr_data_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending set, buffered completions, outstanding issued ops.
    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    bit            pend [NREG];
    wr_t           fq [$];
    logic [AW-1:0] outs [$];
    bit            m_lt_acc, m_iss_acc;

    task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ex_wr_en_i   = 1'b0;
        ex_wr_addr_i = '0;
        ex_wr_data_i = '0;
        iss_valid_i  = 1'b0;
        iss_rd_i     = '0;
        lt_valid_i   = 1'b0;
        lt_rd_i      = '0;
        lt_data_i    = '0;
        rs1_addr_i   = '0;
        rs2_addr_i   = '0;
    endtask

    task automatic model_reset();
        foreach (pend[i]) pend[i] = 1'b0;
        fq.delete();
        outs.delete();
    endtask

    // One clock: check handshake/busy outputs, advance the model, check the write port.
    task automatic cycle();
        bit            exp_en, lt_rdy, iss_rdy, direct;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
        wr_t           e;
        #1;
        lt_rdy  = fq.size() < DEPTH;
        iss_rdy = !pend[iss_rd_i];
        check("lt_ready", lt_ready_o, lt_rdy);
        check("iss_ready", iss_ready_o, iss_rdy);
        check("rs1_busy", rs1_busy_o, pend[rs1_addr_i] && rs1_addr_i != 0);
        check("rs2_busy", rs2_busy_o, pend[rs2_addr_i] && rs2_addr_i != 0);
        m_lt_acc  = lt_valid_i && lt_rdy;
        m_iss_acc = iss_valid_i && iss_rdy;
        exp_en = 1'b1;
        direct = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        if (ex_wr_en_i && ex_wr_addr_i != 0) begin
            exp_addr = ex_wr_addr_i;
            exp_data = ex_wr_data_i;
        end else if (fq.size() != 0) begin
            e = fq.pop_front();
            exp_addr = e.rd;
            exp_data = e.data;
            pend[e.rd] = 1'b0;
        end else if (m_lt_acc && lt_rd_i != 0) begin
            exp_addr = lt_rd_i;
            exp_data = lt_data_i;
            pend[lt_rd_i] = 1'b0;
            direct = 1'b1;
        end else begin
            exp_en = 1'b0;
        end
        if (m_lt_acc && lt_rd_i != 0 && !direct) fq.push_back('{lt_rd_i, lt_data_i});
        if (m_iss_acc && iss_rd_i != 0) pend[iss_rd_i] = 1'b1;
        @(posedge clk);
        #1;
        check("wr_en", reg_wr_en_o, exp_en);
        if (exp_en) begin
            check("wr_addr", reg_wr_addr_o, exp_addr);
            check("wr_data", reg_wr_data_o, exp_data);
        end
    endtask

    // Raise reset between edges and confirm the effect is immediate and total.
    task automatic reset_mid_cycle();
        idle();
        #3;
        rst = 1'b1;
        #1;
        check("rst_wr_en", reg_wr_en_o, 0);
        check("rst_wr_addr", reg_wr_addr_o, 0);
        check("rst_wr_data", reg_wr_data_o, 0);
        for (int a = 0; a < NREG; a++) begin
            rs1_addr_i = AW'(a);
            #1;
            check("rst_rs1_busy", rs1_busy_o, 0);
        end
        check("rst_lt_ready", lt_ready_o, 1);
        model_reset();
        rs1_addr_i = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_wr_en", reg_wr_en_o, 0);
    endtask

    initial begin
        idle();
        model_reset();

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        check("init_wr_en", reg_wr_en_o, 0);
        check("init_wr_addr", reg_wr_addr_o, 0);
        check("init_wr_data", reg_wr_data_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("init_lt_ready", lt_ready_o, 1);

        // ex-only writes, including a dropped x0 write.
        idle(); ex_wr_en_i = 1'b1; ex_wr_addr_i = 5; ex_wr_data_i = 32'h1234_5678;
        cycle();
        check("ex_x5_addr", reg_wr_addr_o, 5);
        check("ex_x5_data", reg_wr_data_o, 32'h1234_5678);
        idle(); ex_wr_en_i = 1'b1; ex_wr_addr_i = 0; ex_wr_data_i = 32'hFFFF_0000;
        cycle();
        check("ex_x0_dropped", reg_wr_en_o, 0);

        // Issue x7, observe busy, reject a second issue, then complete it.
        idle(); iss_valid_i = 1'b1; iss_rd_i = 7;
        cycle();
        idle(); rs1_addr_i = 7; iss_valid_i = 1'b1; iss_rd_i = 7;
        #1;
        check("x7_busy", rs1_busy_o, 1);
        check("x7_reissue_blocked", iss_ready_o, 0);
        cycle();
        idle(); lt_valid_i = 1'b1; lt_rd_i = 7; lt_data_i = 32'hDEAD_BEEF; rs1_addr_i = 7;
        cycle();
        check("x7_lt_addr", reg_wr_addr_o, 7);
        check("x7_lt_data", reg_wr_data_o, 32'hDEAD_BEEF);
        check("x7_busy_cleared", rs1_busy_o, 0);

        // Conflict buffering: two completions lose to three ex writes.
        idle(); iss_valid_i = 1'b1; iss_rd_i = 9;
        cycle();
        idle(); iss_valid_i = 1'b1; iss_rd_i = 10;
        cycle();
        idle(); ex_wr_en_i = 1'b1; ex_wr_addr_i = 3; ex_wr_data_i = 32'h3;
        lt_valid_i = 1'b1; lt_rd_i = 9; lt_data_i = 32'h9999;
        cycle();
        idle(); ex_wr_en_i = 1'b1; ex_wr_addr_i = 4; ex_wr_data_i = 32'h4;
        lt_valid_i = 1'b1; lt_rd_i = 10; lt_data_i = 32'hAAAA;
        cycle();
        idle(); ex_wr_en_i = 1'b1; ex_wr_addr_i = 6; ex_wr_data_i = 32'h6;
        #1;
        check("conf_full_ready", lt_ready_o, 0);
        cycle();
        check("conf_third_addr", reg_wr_addr_o, 6);
        idle();
        cycle();
        check("conf_fourth_addr", reg_wr_addr_o, 9);
        idle();
        cycle();
        check("conf_fifth_addr", reg_wr_addr_o, 10);

        // Set/clear race on x8.
        idle(); lt_valid_i = 1'b1; lt_rd_i = 8; lt_data_i = 32'h8888;
        iss_valid_i = 1'b1; iss_rd_i = 8;
        cycle();
        idle(); rs2_addr_i = 8;
        #1;
        check("race_x8_busy", rs2_busy_o, 1);
        cycle();

        // Mid-operation reset with pending bits and a full buffer.
        idle(); iss_valid_i = 1'b1; iss_rd_i = 12;
        cycle();
        idle(); ex_wr_en_i = 1'b1; ex_wr_addr_i = 1; ex_wr_data_i = 32'h11;
        lt_valid_i = 1'b1; lt_rd_i = 12; lt_data_i = 32'h1212;
        cycle();
        idle(); ex_wr_en_i = 1'b1; ex_wr_addr_i = 2; ex_wr_data_i = 32'h22;
        lt_valid_i = 1'b1; lt_rd_i = 20; lt_data_i = 32'h2020;
        cycle();
        reset_mid_cycle();
        idle(); rs1_addr_i = 8; rs2_addr_i = 12;
        cycle();
        check("no_drain_after_rst", reg_wr_en_o, 0);

        // Randomized bursts: alternating ex-heavy and lt-heavy phases.
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 8; c++) begin
                logic [AW-1:0] a;
                idle();
                if ($urandom_range(0, 1) == 1) begin
                    iss_valid_i = 1'b1;
                    iss_rd_i    = AW'($urandom_range(1, NREG - 1));
                end
                if (outs.size() != 0 && $urandom_range(0, 3) != 0) begin
                    lt_valid_i = 1'b1;
                    lt_rd_i    = outs[0];
                    lt_data_i  = $urandom;
                end
                if ($urandom_range(0, 3) < ((b % 2 == 0) ? 3 : 1)) begin
                    a = AW'($urandom_range(0, NREG - 1));
                    if (!pend[a]) begin
                        ex_wr_en_i   = 1'b1;
                        ex_wr_addr_i = a;
                        ex_wr_data_i = $urandom;
                    end
                end
                rs1_addr_i = AW'($urandom_range(0, NREG - 1));
                rs2_addr_i = AW'($urandom_range(0, NREG - 1));
                cycle();
                if (m_lt_acc) void'(outs.pop_front());
                if (m_iss_acc && iss_rd_i != 0) outs.push_back(iss_rd_i);
            end
        end

        // Drain every outstanding completion, bounded.
        for (int i = 0; i < 200 && (outs.size() != 0 || fq.size() != 0); i++) begin
            idle();
            if (outs.size() != 0) begin
                lt_valid_i = 1'b1;
                lt_rd_i    = outs[0];
                lt_data_i  = $urandom;
            end
            cycle();
            if (m_lt_acc) void'(outs.pop_front());
        end
        check("drain_done", DW'(outs.size() + fq.size()), 0);
        idle();
        cycle();
        for (int a = 0; a < NREG; a++) begin
            rs1_addr_i = AW'(a);
            rs2_addr_i = AW'(NREG - 1 - a);
            #1;
            check("final_rs1_busy", rs1_busy_o, 0);
            check("final_rs2_busy", rs2_busy_o, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
